// File: rtl/icache.sv
// Direct-mapped instruction cache with 128-bit lines and a 4-beat memory refill.
// Hit/miss performance counters exist only when ICACHE_PERF_CNT_EN is defined.
module icache #(
    parameter int unsigned NUM_SETS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pc_in,
    input  logic         cache_rd_en,
    input  logic         cache_abort,
    output logic [127:0] dout,
    output logic         dout_valid,
    output logic         busy,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ready,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_rvalid,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {StIdle, StReq, StFill, StResp} state_e;

    state_e              state_q, state_d;
    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [127:0]        data_q [NUM_SETS];
    logic [TAG_W-1:0]    req_tag_q;
    logic [IDX_W-1:0]    req_idx_q;
    logic [1:0]          beat_q;
    logic [95:0]         fill_q;
    logic                abort_q;
    logic                hit_pend_q;
    logic [127:0]        dout_q;

    logic [IDX_W-1:0]    pc_idx;
    logic [TAG_W-1:0]    pc_tag;
    logic                accept, lookup_hit, hit_acc, miss_acc, last_beat;
    logic [127:0]        fill_line;
    logic                unused_pc_lsbs;

    assign pc_idx         = pc_in[4 +: IDX_W];
    assign pc_tag         = pc_in[31 -: TAG_W];
    assign unused_pc_lsbs = ^pc_in[3:0];
    assign accept         = (state_q == StIdle) && cache_rd_en && !cache_abort;
    assign lookup_hit     = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign hit_acc        = accept && lookup_hit;
    assign miss_acc       = accept && !lookup_hit;
    assign last_beat      = (state_q == StFill) && mem_rvalid && (beat_q == 2'd3);
    assign fill_line      = {mem_rdata, fill_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (miss_acc) state_d = StReq;
            // mem_ready wins over abort; the abort is then latched and honoured at fill end
            StReq: begin
                if (mem_ready) begin
                    state_d = StFill;
                end else if (cache_abort) begin
                    state_d = StIdle;
                end
            end
            StFill: if (last_beat) state_d = (abort_q || cache_abort) ? StIdle : StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req    = (state_q == StReq);
        busy       = (state_q != StIdle);
        dout_valid = (hit_pend_q || (state_q == StResp)) && !cache_abort;
    end

    assign dout     = dout_q;
    assign mem_addr = {req_tag_q, req_idx_q, 4'b0000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            req_tag_q  <= '0;
            req_idx_q  <= '0;
            beat_q     <= 2'd0;
            fill_q     <= '0;
            abort_q    <= 1'b0;
            hit_pend_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            hit_pend_q <= hit_acc;
            if (hit_acc) begin
                dout_q <= data_q[pc_idx];
            end
            if (miss_acc) begin
                req_tag_q <= pc_tag;
                req_idx_q <= pc_idx;
            end
            if (state_q == StIdle) begin
                abort_q <= 1'b0;
            end else if (cache_abort && ((state_q == StFill) || (state_q == StReq && mem_ready))) begin
                abort_q <= 1'b1;
            end
            if (state_q == StReq) begin
                beat_q <= 2'd0;
            end
            if (state_q == StFill && mem_rvalid) begin
                beat_q <= beat_q + 2'd1;
                case (beat_q)
                    2'd0:    fill_q[31:0]  <= mem_rdata;
                    2'd1:    fill_q[63:32] <= mem_rdata;
                    2'd2:    fill_q[95:64] <= mem_rdata;
                    default: ;
                endcase
            end
            if (last_beat) begin
                valid_q[req_idx_q] <= 1'b1;
                dout_q             <= fill_line;
            end
        end
    end

    // Line storage needs no reset: the valid bits gate every lookup.
    always_ff @(posedge clk) begin
        if (last_beat) begin
            tag_q[req_idx_q]  <= req_tag_q;
            data_q[req_idx_q] <= fill_line;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_acc && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_acc && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
